// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op encodings, widths, default latencies and op classification.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
package mdu_pkg;

   localparam int OP_W         = 4;
   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;

   typedef enum logic [OP_W-1:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   // Multiply-accumulate codes only join the multiply class when compiled in.
   function automatic logic is_mult_op(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      return op inside {OP_MULT, OP_MULTU};
`endif
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - MDU issue/result bundle between execute stage (master) and mdu (slave).
interface mdu_if;
   import mdu_pkg::*;

   logic            start;
   logic [OP_W-1:0] op;
   logic [31:0]     A;
   logic [31:0]     B;
   logic            busy;
   logic [31:0]     HI;
   logic [31:0]     LO;

   modport master (output start, op, A, B, input busy, HI, LO);
   modport slave  (input start, op, A, B, output busy, HI, LO);

endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational result datapath for captured MDU operands.
// Optional feature macro: MDU_MADD_EN (adds HI/LO accumulate inputs).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   input  logic [31:0]     a_i,
   input  logic [31:0]     b_i,
`ifdef MDU_MADD_EN
   input  logic [31:0]     hi_i,
   input  logic [31:0]     lo_i,
`endif
   output logic [63:0]     res_o,
   output logic            we_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quot;
   logic [31:0] rem;

   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'b0, a_i} * {32'b0, b_i};

   always_comb begin
      res_o = '0;
      we_o  = 1'b0;
      quot  = '0;
      rem   = '0;
      case (op_i)
         OP_MULT: begin
            res_o = prod_s;
            we_o  = 1'b1;
         end
         OP_MULTU: begin
            res_o = prod_u;
            we_o  = 1'b1;
         end
         OP_DIV: begin
            if (b_i != 32'd0) begin
               // Most-negative / -1 overflows; pin the wrapped quotient explicitly.
               if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                  quot = 32'h8000_0000;
                  rem  = 32'd0;
               end else begin
                  quot = $signed(a_i) / $signed(b_i);
                  rem  = $signed(a_i) % $signed(b_i);
               end
               res_o = {rem, quot};
               we_o  = 1'b1;
            end
         end
         OP_DIVU: begin
            if (b_i != 32'd0) begin
               quot  = a_i / b_i;
               rem   = a_i % b_i;
               res_o = {rem, quot};
               we_o  = 1'b1;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            res_o = {hi_i, lo_i} + prod_s;
            we_o  = 1'b1;
         end
         OP_MADDU: begin
            res_o = {hi_i, lo_i} + prod_u;
            we_o  = 1'b1;
         end
         OP_MSUB: begin
            res_o = {hi_i, lo_i} - prod_s;
            we_o  = 1'b1;
         end
         OP_MSUBU: begin
            res_o = {hi_i, lo_i} - prod_u;
            we_o  = 1'b1;
         end
`endif
         default: begin
            res_o = '0;
            we_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit: HI/LO owner with fixed-latency busy counter.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU with MULT_LAT).
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic  clk,
   input  logic  rst,
   mdu_if.slave  bus
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [63:0]      arith_res;
   logic             arith_we;

   mdu_arith u_arith (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
`ifdef MDU_MADD_EN
      .hi_i  (hi_q),
      .lo_i  (lo_q),
`endif
      .res_o (arith_res),
      .we_o  (arith_we)
   );

   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (cnt_q != '0) begin
         // Busy: every start is dropped, including MTHI/MTLO.
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1) && arith_we) begin
            {hi_d, lo_d} = arith_res;
         end
      end else if (bus.start) begin
         if (bus.op == OP_MTHI) begin
            hi_d = bus.A;
         end else if (bus.op == OP_MTLO) begin
            lo_d = bus.A;
         end else if (is_mult_op(bus.op) || is_div_op(bus.op)) begin
            op_d  = bus.op;
            a_d   = bus.A;
            b_d   = bus.B;
            cnt_d = is_div_op(bus.op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   assign bus.busy = (cnt_q != '0);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu against an arithmetic reference model.
// Follows MDU_MADD_EN for the expected behaviour of codes 7-10.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_if bus ();

   mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: new {HI,LO} and latency derived from the architectural rules.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] r, output int lat);
      longint sa;
      longint sb;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r   = {m_hi, m_lo};
      lat = 0;
      case (op)
         4'd1: begin lat = MULT_LAT; r = 64'(sa * sb); end
         4'd2: begin lat = MULT_LAT; r = 64'(ua * ub); end
         4'd3: begin lat = DIV_LAT; if (b != 0) r = {32'(sa % sb), 32'(sa / sb)}; end
         4'd4: begin lat = DIV_LAT; if (b != 0) r = {32'(ua % ub), 32'(ua / ub)}; end
         4'd5: r = {a, m_lo};
         4'd6: r = {m_hi, a};
`ifdef MDU_MADD_EN
         4'd7:  begin lat = MULT_LAT; r = {m_hi, m_lo} + 64'(sa * sb); end
         4'd8:  begin lat = MULT_LAT; r = {m_hi, m_lo} + 64'(ua * ub); end
         4'd9:  begin lat = MULT_LAT; r = {m_hi, m_lo} - 64'(sa * sb); end
         4'd10: begin lat = MULT_LAT; r = {m_hi, m_lo} - 64'(ua * ub); end
`endif
         default: ;
      endcase
   endtask

   // Called just after a negedge; issues the op there and ends after the result negedge.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
      logic [63:0] r;
      int          lat;
      model(op, a, b, r, lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      for (int c = 1; c <= lat; c++) begin
         chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
         chk({tag, " hi hold"}, bus.HI, m_hi);
         chk({tag, " lo hold"}, bus.LO, m_lo);
         if (c == 1 && poke) begin
            bus.start = 1'b1;
            bus.op    = OP_MTHI;
            bus.A     = 32'h1234;
         end else begin
            bus.start = 1'b0;
            bus.A     = $urandom;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, " hi"}, bus.HI, r[63:32]);
      chk({tag, " lo"}, bus.LO, r[31:0]);
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      checks    = 0;
      errors    = 0;
      m_hi      = '0;
      m_lo      = '0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.A     = '0;
      bus.B     = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset hi", bus.HI, 32'd0);
      chk("reset lo", bus.LO, 32'd0);

      do_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      do_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
      do_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_op("divu", OP_DIVU, 32'd7, 32'd2, 1'b0);
      do_op("mthi", OP_MTHI, 32'h11, 32'd0, 1'b0);
      do_op("mtlo", OP_MTLO, 32'h22, 32'd0, 1'b0);
      do_op("div0", OP_DIV, 32'h1357, 32'd0, 1'b0);
      do_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op("mult poked", OP_MULT, 32'h0001_0003, 32'h0000_0007, 1'b1);
      do_op("mthi idle", OP_MTHI, 32'h1234, 32'd0, 1'b0);
      do_op("none", OP_NONE, 32'hDEAD_BEEF, 32'd1, 1'b0);
      do_op("rsvd", 4'd13, 32'hDEAD_BEEF, 32'd1, 1'b0);
      do_op("mthi0", OP_MTHI, 32'd0, 32'd0, 1'b0);
      do_op("mtlo1s", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
      do_op("maddu", OP_MADDU, 32'd1, 32'd1, 1'b0);
      do_op("msub", OP_MSUB, 32'hFFFF_FFFD, 32'd5, 1'b0);

      // Reset mid-multiply discards the in-flight result.
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.A     = 32'd9;
      bus.B     = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("rst mid busy", {31'd0, bus.busy}, 32'd0);
      chk("rst mid hi", bus.HI, 32'd0);
      chk("rst mid lo", bus.LO, 32'd0);
      repeat (MULT_LAT) @(negedge clk);
      chk("rst discard hi", bus.HI, 32'd0);
      chk("rst discard lo", bus.LO, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'($signed(-$urandom_range(1, 50)));
         do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ($urandom_range(0, 1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the execute stage of the pipelined MIPS core. Consumes the forwarded register-file read operands (rs, rt) and owns the architectural HI/LO registers. mfhi/mflo read HI/LO so the value travels down the pipe into the register-file write port. Models fixed multi-cycle latency with a busy counter so the hazard unit can stall HI/LO consumers and new MDU instructions.

## Interface
- MULT_LAT, 5: busy cycles for mult/multu (and madd-family when compiled in); must be ≥1.
- DIV_LAT, 10: busy cycles for div/divu; must be ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high; clears HI, LO, counter.
- start  in  1  qualifies op this cycle (E-stage instruction is an MDU op, not stalled).
- op  in  4  operation code (encodings in package).
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- busy  out  1  operation in flight; reset 0.
- HI  out  32  architectural HI; reset 0.
- LO  out  32  architectural LO; reset 0.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; 11–15 reserved, treated as NONE.
- Idle state: counter=0, busy=0. Accepts start.
- MTHI/MTLO with start while idle: HI (resp. LO) <= A at that edge; busy stays 0.
- MULT/MULTU/DIV/DIVU with start while idle: A, B, op captured into internal registers; counter <= latency; later input changes have no effect.
- Busy state: counter decrements each edge; at edge where counter==1, HI/LO written and counter -> 0.
- start while busy: ignored entirely (including MTHI/MTLO); hazard unit guarantees it does not happen, unit must still be safe.
- MULT: {HI,LO} = signed A × signed B, 64-bit. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0): HI and LO unchanged; busy still runs full DIV_LAT.
- Reserved/NONE op with start: no state change.
- rst: HI=LO=0, counter=0 at next edge, overrides start and any in-flight op (result discarded).

## Timing
- Cycle 0 start (mult class) -> busy=1 cycles 1..MULT_LAT -> new HI/LO visible cycle MULT_LAT+1 with busy=0.
- Div class identical with DIV_LAT.
- busy is registered (counter!=0); start does not assert busy combinationally — hazard unit combines start|busy itself.
- MTHI/MTLO: new value visible cycle 1.
- Back-to-back: start accepted in the first cycle busy=0 after completion.
- HI/LO outputs are direct register outputs; no internal forwarding.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU implemented with MULT_LAT; {HI,LO} <= {HI,LO} ± product (signed/unsigned product per op, 64-bit wrap), using HI/LO at completion edge.
- Not defined: codes 7–10 behave as NONE (no busy, no state change).

## Structure
- Package mdu_pkg: op encodings, op width, default latencies.
- Sub-module mdu_arith: combinational, captured op/A/B (plus current HI/LO) -> 64-bit result and write-enable (deasserted for divide by zero); mdu holds counter, capture registers and HI/LO.

## Test plan
- Reset: rst high 1 cycle mid MULT -> HI=LO=0, busy=0 next cycle; result never appears.
- MULT A=0xFFFFFFFE (−2), B=3 -> busy cycles 1–5, cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 -> busy cycles 1–10, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIV by zero with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22; DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- MTHI A=0x1234 while busy -> ignored; while idle -> HI=0x1234 cycle 1, busy stays 0; operand change during busy does not alter result.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1, LO=0 after MULT_LAT; without macro -> no busy, HI/LO unchanged.
